// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative inverse cipher:
// S-box tables, Rcon, GF(2^8) multiply helpers, the 4x4 byte state type
// and the controller state encoding.
package aes_pkg;

   localparam int NUM_ROUNDS = 10;

   // Column-major 4x4 byte state: state[c][r]; element [0][0] is bits [127:120].
   typedef logic [0:3][0:3][7:0] state_t;

   typedef enum logic [1:0] {
      IDLE,
      KEYEXP,
      ROUND,
      HOLD
   } fsm_state_t;

   // Round constants indexed by round number; unused slots padded with zero.
   localparam logic [0:15][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX_TABLE = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[x];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TABLE[x];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] gf_mul2(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul8(input logic [7:0] x);
      return gf_mul2(gf_mul2(gf_mul2(x)));
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] x);
      return gf_mul8(x) ^ x;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] x);
      return gf_mul8(x) ^ gf_mul2(x) ^ x;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] x);
      return gf_mul8(x) ^ gf_mul2(gf_mul2(x)) ^ x;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] x);
      return gf_mul8(x) ^ gf_mul2(gf_mul2(x)) ^ gf_mul2(x);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round in the equivalent-order used here:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last_round.
module aes_inv_round
   import aes_pkg::*;
(
   input  state_t       state_in,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output state_t       state_out
);

   state_t subbed;
   state_t keyed;
   state_t mixed;

   // Row r rotates right by r positions, then every byte goes through the inverse S-box.
   always_comb begin
      subbed = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            subbed[c][r] = inv_sbox(state_in[(c + 4 - r) % 4][r]);
         end
      end
   end

   assign keyed = subbed ^ round_key;

   // InvMixColumns on each column of the keyed state.
   always_comb begin
      mixed = '0;
      for (int c = 0; c < 4; c++) begin
         mixed[c][0] = gf_mul14(keyed[c][0]) ^ gf_mul11(keyed[c][1]) ^
                       gf_mul13(keyed[c][2]) ^ gf_mul9(keyed[c][3]);
         mixed[c][1] = gf_mul9(keyed[c][0])  ^ gf_mul14(keyed[c][1]) ^
                       gf_mul11(keyed[c][2]) ^ gf_mul13(keyed[c][3]);
         mixed[c][2] = gf_mul13(keyed[c][0]) ^ gf_mul9(keyed[c][1])  ^
                       gf_mul14(keyed[c][2]) ^ gf_mul11(keyed[c][3]);
         mixed[c][3] = gf_mul11(keyed[c][0]) ^ gf_mul13(keyed[c][1]) ^
                       gf_mul9(keyed[c][2])  ^ gf_mul14(keyed[c][3]);
      end
   end

   assign state_out = last_round ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, UNROLL rounds per clock, with cached
// round keys and valid/ready handshakes on both sides.
// Optional CBC chaining is enabled by defining AES_CBC_EN (adds iv_in).
module aes_decrypt_iter
   import aes_pkg::*;
#(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_load,
   input  logic [127:0] key_in,
`ifdef AES_CBC_EN
   input  logic [127:0] iv_in,
`endif
   output logic         key_rdy,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] cipher_text,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] plain_text
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
      $error("aes_decrypt_iter: UNROLL must be 1, 2, 5 or 10");
   end

   fsm_state_t   state;
   fsm_state_t   next_state;
   logic [127:0] rk [0:NUM_ROUNDS];
   logic [3:0]   key_cnt;
   logic [3:0]   round_cnt;
   logic [127:0] prev_key;
   logic [127:0] next_key;
   logic [31:0]  key_temp;
   logic [127:0] out_mask;
   state_t       work;
   state_t       stage [0:UNROLL];
   logic [3:0]   ridx  [0:UNROLL-1];
   logic         load_key;
   logic         accept;
   logic         last_step;

   // A key load is honoured only while no block is in flight.
   assign load_key  = key_load && (state == IDLE || state == KEYEXP);
   assign accept    = in_valid && in_ready;
   assign last_step = (round_cnt == 4'(UNROLL));

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and in_ready; in_ready drops under key_load so a block is never
   // offered a handshake that the key reload would then discard.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = key_rdy && !key_load;
            if (key_load) begin
               next_state = KEYEXP;
            end else if (in_valid && key_rdy) begin
               next_state = ROUND;
            end
         end
         KEYEXP: begin
            if (!key_load && key_cnt == 4'(NUM_ROUNDS + 1)) begin
               next_state = IDLE;
            end
         end
         ROUND: begin
            if (last_step) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Forward key schedule step from the previously written round key.
   always_comb begin
      prev_key = rk[key_cnt - 4'd1];
      key_temp = sub_word({prev_key[23:0], prev_key[31:24]}) ^ {RCON[key_cnt], 24'h0};
      next_key[127:96] = prev_key[127:96] ^ key_temp;
      next_key[95:64]  = prev_key[95:64]  ^ next_key[127:96];
      next_key[63:32]  = prev_key[63:32]  ^ next_key[95:64];
      next_key[31:0]   = prev_key[31:0]   ^ next_key[63:32];
   end

   // Round-key store: rk[0] on load, one key per cycle, then a settle cycle before key_rdy.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_rdy <= 1'b0;
         key_cnt <= '0;
      end else if (load_key) begin
         rk[0]   <= key_in;
         key_cnt <= 4'd1;
         key_rdy <= 1'b0;
      end else if (state == KEYEXP) begin
         if (key_cnt <= 4'(NUM_ROUNDS)) begin
            rk[key_cnt] <= next_key;
            key_cnt     <= key_cnt + 4'd1;
         end else begin
            key_rdy <= 1'b1;
         end
      end
   end

   assign stage[0] = work;

   for (genvar i = 0; i < UNROLL; i++) begin : g_round
      assign ridx[i] = round_cnt - 4'(i + 1);
      aes_inv_round u_round (
         .state_in   (stage[i]),
         .round_key  (rk[ridx[i]]),
         .last_round (ridx[i] == 4'd0),
         .state_out  (stage[i + 1])
      );
   end

`ifdef AES_CBC_EN
   logic [127:0] chain;
   logic [127:0] block_iv;

   // Chain register: IV on key load, then each accepted ciphertext; block_iv keeps the mask for the block in flight.
   always_ff @(posedge clk) begin
      if (load_key) begin
         chain <= iv_in;
      end else if (accept) begin
         block_iv <= chain;
         chain    <= cipher_text;
      end
   end

   assign out_mask = block_iv;
`else
   assign out_mask = '0;
`endif

   // Block datapath: initial AddRoundKey on accept, UNROLL rounds per cycle, then hold the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         plain_text <= '0;
         round_cnt  <= '0;
         work       <= '0;
      end else if (accept) begin
         work      <= cipher_text ^ rk[NUM_ROUNDS];
         round_cnt <= 4'(NUM_ROUNDS);
      end else if (state == ROUND) begin
         work      <= stage[UNROLL];
         round_cnt <= round_cnt - 4'(UNROLL);
         if (last_step) begin
            plain_text <= stage[UNROLL] ^ out_mask;
            out_valid  <= 1'b1;
         end
      end else if (state == HOLD && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed testbench for aes_decrypt_iter using FIPS-197 / SP800-38A vectors.
// A main instance (UNROLL=1) is checked in depth; three extra instances
// (UNROLL=2,5,10) share its inputs and are checked for C.1 latency and result.
module tb_aes_decrypt_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CBC_IV  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CBC_CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
   localparam logic [127:0] CBC_PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] CBC_CT2 = 128'h5086cb9b507219ee95db113a917678b2;
   localparam logic [127:0] CBC_PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_load;
   logic [127:0] key_in;
   logic [127:0] iv_in;
   logic         key_rdy;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] cipher_text;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] plain_text;

   logic         ext_key_rdy   [3];
   logic         ext_in_ready  [3];
   logic         ext_out_valid [3];
   logic [127:0] ext_plain     [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_decrypt_iter #(.UNROLL(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_load    (key_load),
      .key_in      (key_in),
`ifdef AES_CBC_EN
      .iv_in       (iv_in),
`endif
      .key_rdy     (key_rdy),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cipher_text (cipher_text),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .plain_text  (plain_text)
   );

   for (genvar g = 0; g < 3; g++) begin : g_ext
      aes_decrypt_iter #(.UNROLL(g == 0 ? 2 : (g == 1 ? 5 : 10))) u_ext (
         .clk         (clk),
         .rst         (rst),
         .key_load    (key_load),
         .key_in      (key_in),
`ifdef AES_CBC_EN
         .iv_in       (iv_in),
`endif
         .key_rdy     (ext_key_rdy[g]),
         .in_valid    (in_valid),
         .in_ready    (ext_in_ready[g]),
         .cipher_text (cipher_text),
         .out_valid   (ext_out_valid[g]),
         .out_ready   (out_ready),
         .plain_text  (ext_plain[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_key_load(input logic [127:0] k, input logic [127:0] iv, output int cycles);
      key_in   = k;
      iv_in    = iv;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      cycles = 0;
      while (key_rdy !== 1'b1 && cycles < 20) begin
         tick();
         cycles++;
      end
   endtask

   task automatic send_block(input logic [127:0] ct, output int lat);
      cipher_text = ct;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (key_rdy !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_key_rdy: got %b expected 0", key_rdy);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (plain_text !== 128'h0) begin
         errors++; $display("[TB] FAIL reset_plain_text: got %h expected 0", plain_text);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_key_timing();
      int n;
      key_in   = C1_KEY;
      iv_in    = '0;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      n = 0;
      while (key_rdy !== 1'b1 && n < 20) begin
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL keyexp_in_ready: cycle %0d got %b expected 0", n, in_ready);
         end
         tick();
         n++;
      end
      checks++;
      if (n != 11) begin
         errors++; $display("[TB] FAIL key_rdy_delay: got %0d expected 11", n);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL idle_in_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_c1_all_unroll();
      int           first   [4];
      logic [127:0] got     [4];
      int           lat_exp [4];
      first   = '{-1, -1, -1, -1};
      got     = '{default: 'x};
      lat_exp = '{10, 5, 2, 1};
      cipher_text = C1_CT;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int n = 0; n <= 12; n++) begin
         if (n > 0) tick();
         if (out_valid === 1'b1 && first[0] < 0) begin
            first[0] = n;
            got[0]   = plain_text;
         end
         for (int k = 0; k < 3; k++) begin
            if (ext_out_valid[k] === 1'b1 && first[k + 1] < 0) begin
               first[k + 1] = n;
               got[k + 1]   = ext_plain[k];
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (first[k] != lat_exp[k]) begin
            errors++; $display("[TB] FAIL c1_latency[%0d]: got %0d expected %0d", k, first[k], lat_exp[k]);
         end
         checks++;
         if (got[k] !== C1_PT) begin
            errors++; $display("[TB] FAIL c1_plain[%0d]: got %h expected %h", k, got[k], C1_PT);
         end
      end
      drain();
   endtask

   task automatic test_app_b();
      int n;
      int lat;
      do_key_load(B_KEY, '0, n);
      checks++;
      if (n != 11) begin
         errors++; $display("[TB] FAIL appb_key_delay: got %0d expected 11", n);
      end
      send_block(B_CT, lat);
      checks++;
      if (lat != 10) begin
         errors++; $display("[TB] FAIL appb_latency: got %0d expected 10", lat);
      end
      checks++;
      if (plain_text !== B_PT) begin
         errors++; $display("[TB] FAIL appb_plain: got %h expected %h", plain_text, B_PT);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int lat;
      cipher_text = B_CT;
      in_valid    = 1'b1;
      tick();
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 10) begin
         errors++; $display("[TB] FAIL bp_first_latency: got %0d expected 10", lat);
      end
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (plain_text !== B_PT || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_hold: cycle %0d got pt=%h in_ready=%b out_valid=%b expected pt=%h in_ready=0 out_valid=1",
                     i, plain_text, in_ready, out_valid, B_PT);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL bp_after_handshake: got out_valid=%b in_ready=%b expected out_valid=0 in_ready=1",
                  out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 10) begin
         errors++; $display("[TB] FAIL bp_second_latency: got %0d expected 10", lat);
      end
      checks++;
      if (plain_text !== B_PT) begin
         errors++; $display("[TB] FAIL bp_second_plain: got %h expected %h", plain_text, B_PT);
      end
      drain();
   endtask

   task automatic test_key_load_in_round();
      int lat;
      cipher_text = B_CT;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      key_in   = C1_KEY;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      lat = 2;
      while (out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != 10) begin
         errors++; $display("[TB] FAIL round_keyload_latency: got %0d expected 10", lat);
      end
      checks++;
      if (plain_text !== B_PT) begin
         errors++; $display("[TB] FAIL round_keyload_plain: got %h expected %h", plain_text, B_PT);
      end
      checks++;
      if (key_rdy !== 1'b1) begin
         errors++; $display("[TB] FAIL round_keyload_key_rdy: got %b expected 1", key_rdy);
      end
      drain();
   endtask

   task automatic test_key_load_in_keyexp();
      int n;
      int lat;
      key_in   = C1_KEY;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      do_key_load(B_KEY, '0, n);
      checks++;
      if (n != 11) begin
         errors++; $display("[TB] FAIL keyexp_restart_delay: got %0d expected 11", n);
      end
      send_block(B_CT, lat);
      checks++;
      if (plain_text !== B_PT) begin
         errors++; $display("[TB] FAIL keyexp_restart_plain: got %h expected %h", plain_text, B_PT);
      end
      drain();
   endtask

   task automatic test_reset_mid_round();
      int n;
      int lat;
      logic seen_valid;
      cipher_text = C1_CT;
      in_valid    = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid === 1'b1) seen_valid = 1'b1;
         tick();
      end
      checks++;
      if (seen_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", seen_valid);
      end
      checks++;
      if (key_rdy !== 1'b0 || in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL midrst_key_rdy: got key_rdy=%b in_ready=%b expected 0 0", key_rdy, in_ready);
      end
      do_key_load(C1_KEY, '0, n);
      send_block(C1_CT, lat);
      checks++;
      if (plain_text !== C1_PT) begin
         errors++; $display("[TB] FAIL midrst_plain: got %h expected %h", plain_text, C1_PT);
      end
      drain();
   endtask

   task automatic test_cbc();
      int n;
      int lat;
      do_key_load(B_KEY, CBC_IV, n);
      send_block(CBC_CT1, lat);
      checks++;
      if (plain_text !== CBC_PT1) begin
         errors++; $display("[TB] FAIL cbc_block1: got %h expected %h", plain_text, CBC_PT1);
      end
      drain();
      send_block(CBC_CT2, lat);
      checks++;
      if (plain_text !== CBC_PT2) begin
         errors++; $display("[TB] FAIL cbc_block2: got %h expected %h", plain_text, CBC_PT2);
      end
      drain();
   endtask

   initial begin
      rst         = 1'b1;
      key_load    = 1'b0;
      key_in      = '0;
      iv_in       = '0;
      in_valid    = 1'b0;
      cipher_text = '0;
      out_ready   = 1'b0;
      test_reset();
`ifdef AES_CBC_EN
      test_cbc();
`else
      test_key_timing();
      test_c1_all_unroll();
      test_app_b();
      test_back_to_back();
      test_key_load_in_round();
      test_key_load_in_keyexp();
      test_reset_mid_round();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
